// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port scheduler.
// Producers and the single consumer share one 16-entry FIFO.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_e;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_BURST  = 4;
  localparam int FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin pick: first set request at or
// after ptr, wrapping; one-hot winner plus a found flag.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            found
);

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      int idx;
      idx = (int'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port among NREQ producers with bounded
// round-robin bursts and slots one consumer read between bursts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int DW    = DEF_DW,
  parameter int BURST = DEF_BURST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  grant,
  input  logic             rd_req,
  output logic [DW-1:0]    rd_data,
  output logic             rd_data_valid,
  output logic             fifo_wr,
  output logic [DW-1:0]    fifo_din,
  output logic             fifo_rd,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_dout
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(BURST + 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            rdv_q;

  logic [NREQ-1:0] pick;
  logic            found;
  logic [PW-1:0]   own;
  logic [PW-1:0]   own_nxt;
  logic            own_valid;
  logic            wr_ok;
  logic            rd_ok;
  logic            last_beat;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_q),
    .win   (pick),
    .found (found)
  );

  always_comb begin
    own = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant_q[i]) own = PW'(i);
  end

  assign own_nxt   = (own == PW'(NREQ - 1)) ? '0 : own + 1'b1;
  assign own_valid = |(req_valid & grant_q);
  assign wr_ok     = (state_q == WRITE) && !fifo_full;
  assign rd_ok     = rd_req && !fifo_empty;
  assign last_beat = beat_q == BW'(BURST - 1);

  // ready is a function of grant/state/full only, never of valid
  assign req_ready = wr_ok ? grant_q : '0;
  assign fifo_wr   = wr_ok && own_valid;
  assign fifo_din  = req_data[int'(own)*DW +: DW];
  assign fifo_rd   = (state_q == READ) && !fifo_empty;

  assign grant         = grant_q;
  assign rd_data       = fifo_dout;
  assign rd_data_valid = rdv_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (found && !fifo_full) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = WRITE;
        end else if (rd_ok) begin
          state_d = READ;
        end
      end
      WRITE: begin
        if (fifo_wr) beat_d = beat_q + 1'b1;
        if ((fifo_wr && last_beat) || !own_valid || fifo_full) begin
          rr_d    = own_nxt;
          grant_d = '0;
          state_d = rd_ok ? READ : IDLE;
        end
      end
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      rdv_q   <= fifo_rd;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 16-entry FIFO model,
// producer queues and a write/read scoreboard monitor.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  grant;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          fifo_wr;
  logic [DW-1:0] fifo_din;
  logic          fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;

  fifo_wr_arbiter #(.NREQ(N), .DW(DW), .BURST(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .grant         (grant),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .fifo_wr       (fifo_wr),
    .fifo_din      (fifo_din),
    .fifo_rd       (fifo_rd),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout)
  );

  always #5 clk = ~clk;

  // FIFO model
  logic [DW-1:0] mem [16];
  logic [3:0]    wp, rp;
  logic [4:0]    cnt;

  assign fifo_full  = cnt == 5'd16;
  assign fifo_empty = cnt == 5'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0; wp <= '0; rp <= '0; fifo_dout <= '0;
    end else if (fifo_wr && cnt != 5'd16) begin
      mem[wp] <= fifo_din; wp <= wp + 1'b1; cnt <= cnt + 1'b1;
    end else if (fifo_rd && cnt != 5'd0) begin
      fifo_dout <= mem[rp]; rp <= rp + 1'b1; cnt <= cnt - 1'b1;
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  logic [7:0] pq [N][$];
  logic [7:0] exp_wr[$];
  logic [7:0] exp_rd[$];

  // Scoreboard monitor
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (!rst) prev_rd = 1'b0;
    else begin
      if (fifo_wr || fifo_rd) chk("wr_rd_excl", fifo_wr & fifo_rd, 0);
      if (fifo_wr) begin
        chk("wr_when_full", fifo_full, 0);
        if (exp_wr.size() == 0) begin
          checks++;
          $display("FAIL wr_extra: got %0h want none", fifo_din);
        end else begin
          logic [7:0] e;
          e = exp_wr.pop_front();
          chk("wr_data", fifo_din, e);
          exp_rd.push_back(e);
        end
      end
      if (fifo_rd) chk("rd_when_empty", fifo_empty, 0);
      if (rd_data_valid || prev_rd)
        chk("rdv_timing", rd_data_valid, prev_rd);
      if (rd_data_valid) begin
        if (exp_rd.size() == 0) begin
          checks++;
          $display("FAIL rd_extra: got %0h want none", rd_data);
        end else chk("rd_data", rd_data, exp_rd.pop_front());
      end
      prev_rd = fifo_rd;
    end
  end

  // Producer driver and per-cycle snapshots
  logic [N-1:0] acc;
  logic [N-1:0] last_grant, last_ready;
  logic last_wr, last_rd, last_full, last_rdv;
  logic [N-1:0] g_hist[100], r_hist[100];
  logic w_hist[100], f_hist[100];
  int wr_cnt, rd_cnt;
  logic [11:0] wbits, rbits;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pq[i].size() != 0;
      req_data[i*DW +: DW] = pq[i].size() != 0 ? pq[i][0] : '0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc        = req_valid & req_ready;
    last_grant = grant;
    last_ready = req_ready;
    last_wr    = fifo_wr;
    last_rd    = fifo_rd;
    last_full  = fifo_full;
    last_rdv   = rd_data_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && pq[i].size() != 0) void'(pq[i].pop_front());
    drive();
  endtask

  task automatic run(input int n);
    wr_cnt = 0;
    rd_cnt = 0;
    for (int k = 0; k < n; k++) begin
      step();
      g_hist[k] = last_grant;
      r_hist[k] = last_ready;
      w_hist[k] = last_wr;
      f_hist[k] = last_full;
      wr_cnt += int'(last_wr);
      rd_cnt += int'(last_rd);
    end
  endtask

  task automatic load(input int p, input logic [7:0] base,
                      input int n);
    for (int j = 0; j < n; j++) pq[p].push_back(base + 8'(j));
  endtask

  task automatic expect_seq(input logic [7:0] base, input int n);
    for (int j = 0; j < n; j++) exp_wr.push_back(base + 8'(j));
  endtask

  initial begin
    rst = 1'b0;
    rd_req = 1'b0;
    req_valid = '0;
    req_data = '0;

    // reset held with all producers valid
    for (int i = 0; i < N; i++) load(i, 8'(i * 16), 5);
    drive();
    repeat (3) step();
    chk("rst_grant", last_grant, 0);
    chk("rst_ready", last_ready, 0);
    chk("rst_wr", last_wr, 0);
    chk("rst_rd", last_rd, 0);
    chk("rst_rdv", last_rdv, 0);

    // round robin until FIFO full
    for (int i = 0; i < N; i++) expect_seq(8'(i * 16), 4);
    rst = 1'b1;
    run(21);
    chk("rr_idle", g_hist[0], 0);
    chk("rr_g0", g_hist[1], 4'b0001);
    chk("rr_gap", g_hist[5], 0);
    chk("rr_g1", g_hist[6], 4'b0010);
    chk("rr_g2", g_hist[11], 4'b0100);
    chk("rr_g3", g_hist[16], 4'b1000);
    chk("rr_end", g_hist[20], 0);
    chk("rr_full", f_hist[20], 1);
    chk("rr_words", wr_cnt, 16);

    // drain, then empty-read hold-off
    for (int i = 0; i < N; i++) pq[i].delete();
    drive();
    rd_req = 1'b1;
    run(40);
    chk("drain_reads", rd_cnt, 16);
    run(6);
    chk("empty_no_rd", rd_cnt, 0);
    rd_req = 1'b0;

    // early release by producer 2
    load(2, 8'h2A, 2);
    expect_seq(8'h2A, 2);
    drive();
    run(5);
    chk("er_words", wr_cnt, 2);
    chk("er_grant", g_hist[1], 4'b0100);
    chk("er_hold", g_hist[3], 4'b0100);
    chk("er_ready", r_hist[3], 4'b0100);
    chk("er_release", g_hist[4], 0);
    load(3, 8'h3C, 1);
    load(0, 8'h0D, 1);
    exp_wr.push_back(8'h3C);
    exp_wr.push_back(8'h0D);
    drive();
    run(7);
    chk("er_ptr3", g_hist[1], 4'b1000);
    chk("er_next0", g_hist[4], 4'b0001);
    chk("er_idle", g_hist[6], 0);

    // read interleave with producer 0 streaming
    rd_req = 1'b1;
    run(12);
    chk("il_predrain", rd_cnt, 4);
    load(0, 8'hA0, 10);
    expect_seq(8'hA0, 10);
    drive();
    run(12);
    wbits = '0;
    rbits = '0;
    for (int k = 0; k < 12; k++) wbits = {wbits[10:0], w_hist[k]};
    chk("il_wr_pat", wbits, 12'h79E);
    run(0);
    rd_cnt = 0;
    // rebuild read pattern from a fresh history is not possible; use
    // the wr history plus the read count derived below
    run(40);
    chk("il_drained", exp_rd.size(), 0);
    chk("il_wr_left", exp_wr.size(), 0);
    rd_req = 1'b0;

    // full boundary: 15 entries then producer 1 offers 3
    load(2, 8'h50, 15);
    expect_seq(8'h50, 15);
    drive();
    run(25);
    chk("fb_fill", wr_cnt, 15);
    load(1, 8'hB0, 3);
    expect_seq(8'hB0, 3);
    drive();
    run(4);
    chk("fb_wr1", w_hist[1], 1);
    chk("fb_full", f_hist[2], 1);
    chk("fb_ready", r_hist[2], 0);
    chk("fb_nowr", w_hist[2], 0);
    chk("fb_end", g_hist[3], 0);
    chk("fb_accepted", wr_cnt, 1);
    chk("fb_left", pq[1].size(), 2);
    rd_req = 1'b1;
    run(80);
    chk("fb_wr_done", exp_wr.size(), 0);
    chk("fb_rd_done", exp_rd.size(), 0);
    rd_req = 1'b0;

    // reset during second beat of a burst
    load(0, 8'hC0, 4);
    expect_seq(8'hC0, 2);
    drive();
    run(2);
    chk("mb_beat1", w_hist[1], 1);
    @(negedge clk);
    chk("mb_beat2_wr", fifo_wr, 1);
    #2 rst = 1'b0;
    #1;
    chk("mb_wr_off", fifo_wr, 0);
    chk("mb_grant_off", grant, 0);
    chk("mb_ready_off", req_ready, 0);
    exp_wr.delete();
    exp_rd.delete();
    for (int i = 0; i < N; i++) pq[i].delete();
    @(posedge clk);
    #1 drive();
    step();
    step();
    rst = 1'b1;
    load(1, 8'hD0, 1);
    load(3, 8'hD3, 1);
    exp_wr.push_back(8'hD0);
    exp_wr.push_back(8'hD3);
    drive();
    run(8);
    chk("mb_idle", g_hist[0], 0);
    chk("mb_ptr_rst", g_hist[1], 4'b0010);
    chk("mb_next", g_hist[4], 4'b1000);
    chk("mb_wr_done", exp_wr.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // read-slot pattern during the interleave window
  int il_k = -1;
  logic [11:0] il_rbits = '0;
  always @(negedge clk) begin
    if (il_k >= 0 && il_k < 12) begin
      il_rbits = {il_rbits[10:0], fifo_rd};
      il_k++;
      if (il_k == 12) chk("il_rd_pat", il_rbits, 12'h041);
    end
    if (il_k < 0 && rd_req && pq[0].size() == 10 &&
        req_valid[0] && grant == 0)
      il_k = 0;
    if (il_k == 0) begin
      il_rbits = {il_rbits[10:0], fifo_rd};
      il_k = 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
